// File: rtl/mult32_seq_ctrl.sv
// mult32_seq_ctrl: sequential 32x32->64 shift-add multiplier controller.
// A single ripple-carry adder (rc_add_sub_32, add mode) is reused across
// 32 iterations. Results are presented on registered hi_o/lo_o.
// Optional feature macro: MULT_SIGNED_EN
//   defined   : signed_i honoured (magnitude in, negate out via FIX state),
//               latency 33 edges from accepting edge to done_o.
//   undefined : signed_i ignored, no FIX state, latency 32 edges.

// Ripple-carry adder/subtractor; sna_i=1 subtracts (a_i - b_i).
module rc_add_sub_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sna_i,
  output logic [31:0] s_o,
  output logic        c_o
);
  logic [31:0] bx;
  logic        carry;

  assign bx = b_i ^ {32{sna_i}};

  // Bit-serial ripple through the 32 full adders.
  always_comb begin
    s_o   = '0;
    carry = sna_i;
    for (int i = 0; i < 32; i++) begin
      s_o[i] = a_i[i] ^ bx[i] ^ carry;
      carry  = (a_i[i] & bx[i]) | (carry & (a_i[i] ^ bx[i]));
    end
    c_o = carry;
  end
endmodule

// Handshake: start_i is a request sampled only while idle (busy_o=0,
// done_o=0); there is no ready/backpressure. Requests made while busy or
// during the done cycle are dropped, not queued. done_o pulses for exactly
// one cycle and hi_o/lo_o are valid from that cycle until the next result.
module mult32_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcnd_q;
  logic [31:0] p_hi_q;
  logic [31:0] p_lo_q;
  logic [5:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        accept;
  logic        iter_en;
  logic        load_res;
  logic        last_iter;

  logic [31:0] add_sum;
  logic        add_cout;
  logic [32:0] step_hi;
  logic [63:0] step_prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_in;

`ifdef MULT_SIGNED_EN
  logic        neg_q;
  logic [63:0] prod_cur;
  logic [63:0] prod_fixed;
`else
  logic        unused_signed;
  assign unused_signed = signed_i;
`endif

  // Shared adder: partial-high plus multiplicand, always in add mode.
  rc_add_sub_32 u_add (
    .a_i   (p_hi_q),
    .b_i   (mcnd_q),
    .sna_i (1'b0),
    .s_o   (add_sum),
    .c_o   (add_cout)
  );

  assign step_hi   = p_lo_q[0] ? {add_cout, add_sum} : {1'b0, p_hi_q};
  assign step_prod = {step_hi, p_lo_q[31:1]};
  assign last_iter = (cnt_q == 6'd31);

`ifdef MULT_SIGNED_EN
  assign a_mag      = (signed_i && a_i[31]) ? (~a_i + 32'd1) : a_i;
  assign b_mag      = (signed_i && b_i[31]) ? (~b_i + 32'd1) : b_i;
  assign neg_in     = signed_i & (a_i[31] ^ b_i[31]);
  assign prod_cur   = {p_hi_q, p_lo_q};
  assign prod_fixed = neg_q ? (~prod_cur + 64'd1) : prod_cur;
`else
  assign a_mag  = a_i;
  assign b_mag  = b_i;
  assign neg_in = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_ITER;
      S_ITER: begin
        if (last_iter) begin
`ifdef MULT_SIGNED_EN
          state_d = S_FIX;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath enables.
  always_comb begin
    busy_o   = 1'b0;
    done_o   = 1'b0;
    accept   = 1'b0;
    iter_en  = 1'b0;
    load_res = 1'b0;
    case (state_q)
      S_IDLE: accept = start_i;
      S_ITER: begin
        busy_o  = 1'b1;
        iter_en = 1'b1;
`ifndef MULT_SIGNED_EN
        load_res = last_iter;
`endif
      end
      S_FIX: begin
        busy_o = 1'b1;
`ifdef MULT_SIGNED_EN
        load_res = 1'b1;
`endif
      end
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, shift-add iteration, result load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcnd_q <= '0;
      p_hi_q <= '0;
      p_lo_q <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MULT_SIGNED_EN
      neg_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        mcnd_q <= a_mag;
        p_lo_q <= b_mag;
        p_hi_q <= '0;
        cnt_q  <= '0;
`ifdef MULT_SIGNED_EN
        neg_q  <= neg_in;
`endif
      end
      if (iter_en) begin
        {p_hi_q, p_lo_q} <= step_prod;
        cnt_q            <= cnt_q + 6'd1;
      end
      if (load_res) begin
`ifdef MULT_SIGNED_EN
        {hi_q, lo_q} <= prod_fixed;
`else
        {hi_q, lo_q} <= step_prod;
`endif
      end
    end
  end

`ifndef MULT_SIGNED_EN
  logic unused_neg;
  assign unused_neg = neg_in;
`endif

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Bench for mult32_seq_ctrl: directed corner cases plus random operands,
// checked against an arithmetic product model and fixed latency.
module tb_mult32_seq_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [1:0]  dbg_state_o;

  int checks;
  int errors;

  logic [63:0] exp_q[$];
  logic [63:0] last_res;

`ifdef MULT_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  mult32_seq_ctrl #(.WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock generation.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference product: 64-bit product of the (sign-extended when signed) operands.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {32'b0, a};
    eb = {32'b0, b};
`ifdef MULT_SIGNED_EN
    if (s) begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end
`else
    if (s) ea = {32'b0, a};
`endif
    return ea * eb;
  endfunction

  // Drive a request to be sampled at the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    a_i      = a;
    b_i      = b;
    signed_i = s;
    start_i  = 1'b1;
    exp_q.push_back(model(a, b, s));
  endtask

  // Follow one accepted request through to done; optional ignored re-request at edge k+reissue_n+1.
  task automatic track(input string name, input int reissue_n, input bit chain,
                       input logic [31:0] na, input logic [31:0] nb, input logic ns);
    logic [63:0] exp;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    signed_i = 1'($urandom_range(0, 1));
    exp = exp_q.pop_front();
    for (int n = 1; n <= LAT; n++) begin
      @(posedge clk_i); #1;
      if (n < LAT) begin
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1 || {hi_o, lo_o} !== last_res) begin
          errors++;
          $display("FAIL %s mid n=%0d: done=%b busy=%b hilo=%h, want done=0 busy=1 hilo=%h",
                   name, n, done_o, busy_o, {hi_o, lo_o}, last_res);
        end
      end else begin
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || {hi_o, lo_o} !== exp) begin
          errors++;
          $display("FAIL %s result: done=%b busy=%b hilo=%h, want done=1 busy=0 hilo=%h",
                   name, done_o, busy_o, {hi_o, lo_o}, exp);
        end
      end
      if (reissue_n != 0 && n == reissue_n) begin
        a_i     = 32'd2;
        b_i     = 32'd2;
        start_i = 1'b1;
      end
      if (reissue_n != 0 && n == reissue_n + 1) start_i = 1'b0;
    end
    last_res = exp;
    @(posedge clk_i); #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || {hi_o, lo_o} !== last_res) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b hilo=%h, want done=0 busy=0 hilo=%h",
               name, done_o, busy_o, {hi_o, lo_o}, last_res);
    end
    if (chain) issue(na, nb, ns);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    last_res = '0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all 0", busy_o, done_o, hi_o, lo_o);
    end
  endtask

  task automatic test_directed();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    track("t1_unsigned_max", 0, 0, 0, 0, 0);
    checks++;
    if (hi_o !== 32'hFFFFFFFE || lo_o !== 32'h00000001) begin
      errors++;
      $display("FAIL t1_const: hi=%h lo=%h, want FFFFFFFE 00000001", hi_o, lo_o);
    end
    issue(32'hFFFFFFFD, 32'h00000005, 1'b1);
    track("t2_t6_neg3x5", 0, 0, 0, 0, 0);
    checks++;
`ifdef MULT_SIGNED_EN
    if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL t2_const: hi=%h lo=%h, want FFFFFFFF FFFFFFF1", hi_o, lo_o);
    end
`else
    if (hi_o !== 32'h00000004 || lo_o !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL t6_const: hi=%h lo=%h, want 00000004 FFFFFFF1", hi_o, lo_o);
    end
`endif
    issue(32'h80000000, 32'h80000000, 1'b1);
    track("t3_min_sq", 0, 0, 0, 0, 0);
    issue(32'h00000000, 32'h12345678, 1'b1);
    track("zero_operand", 0, 0, 0, 0, 0);
    issue(32'h7FFFFFFF, 32'h80000000, 1'b1);
    track("max_x_min", 0, 0, 0, 0, 0);
  endtask

  task automatic test_ignore_start();
    issue(32'h0000ABCD, 32'h00001234, 1'b0);
    track("t4_ignore", 4, 0, 0, 0, 0);
    // One more idle edge: the dropped request must not start a run.
    @(posedge clk_i); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL t4_not_queued: busy=%b done=%b, want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(32'hDEADBEEF, 32'hCAFEF00D, 1'b0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    void'(exp_q.pop_front());
    repeat (9) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    last_res = '0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL t5_reset: busy=%b done=%b hi=%h lo=%h, want all 0", busy_o, done_o, hi_o, lo_o);
    end
    issue(32'd7, 32'd6, 1'b0);
    track("t5_after_reset", 0, 0, 0, 0, 0);
    checks++;
    if (lo_o !== 32'h0000002A || hi_o !== 32'd0) begin
      errors++;
      $display("FAIL t5_const: hi=%h lo=%h, want 00000000 0000002A", hi_o, lo_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    issue($urandom, $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      track("back_to_back", 0, (i < 3), ra, rb, rs);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) ra = 32'($urandom_range(0, 15));
      if (i % 4 == 2) rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1;
      issue(ra, rb, 1'($urandom_range(0, 1)));
      track("random", 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
